// File: rtl/memstream_loader_pkg.sv
// Shared types and helpers for the memstream configuration-port loader.
// Optional verify pass is enabled with the MEMSTREAM_LOADER_VERIFY_EN macro.
package memstream_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FLUSH  = 3'd2,
        S_VERIFY = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Counter width for an address range of 0..depth-1, never narrower than one bit.
    function automatic int cnt_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/memstream_xsum.sv
// XOR checksum accumulator: clr zeroes the sum, en folds d into it.
module memstream_xsum #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] sum_reg;

    // Accumulate; clear has priority so a new load always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (clr) begin
            sum_reg <= '0;
        end else if (en) begin
            sum_reg <= sum_reg ^ d;
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/memstream_loader.sv
// Stream-to-config-port loader: one registered config write per accepted beat,
// addresses 0..DEPTH-1. With MEMSTREAM_LOADER_VERIFY_EN defined, a readback pass
// compares XOR checksums of written and read-back words and flags a mismatch.
module memstream_loader
    import memstream_loader_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    input  logic [WIDTH-1:0] idat,
    input  logic             ivld,
    output logic             irdy,
    output logic             config_ce,
    output logic             config_we,
    output logic [31:0]      config_address,
    output logic [WIDTH-1:0] config_d0,
    input  logic             config_rack,
    input  logic [WIDTH-1:0] config_q0
);

    localparam int            CW   = cnt_width(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    wr_cnt_reg;
    logic             ce_reg, we_reg;
    logic [31:0]      addr_reg;
    logic [WIDTH-1:0] d0_reg;

    logic start_acc, accept, last_accept;

    assign start_acc   = (state_reg == S_IDLE) && start;
    assign accept      = (state_reg == S_LOAD) && ivld;
    assign last_accept = accept && (wr_cnt_reg == LAST);

`ifdef MEMSTREAM_LOADER_VERIFY_EN
    logic [CW-1:0]    rd_cnt_reg, rsp_cnt_reg;
    logic             rd_all_reg, error_reg;
    logic [WIDTH-1:0] wsum, rsum;
    logic             rack_ok, last_rack;

    assign rack_ok   = (state_reg == S_VERIFY) && config_rack;
    assign last_rack = rack_ok && (rsp_cnt_reg == LAST);

    memstream_xsum #(.WIDTH(WIDTH)) u_wsum (
        .clk (clk), .rst (rst), .clr (start_acc), .en (accept),  .d (idat),      .sum (wsum)
    );
    memstream_xsum #(.WIDTH(WIDTH)) u_rsum (
        .clk (clk), .rst (rst), .clr (start_acc), .en (rack_ok), .d (config_q0), .sum (rsum)
    );
`else
    logic unused_rack;
    assign unused_rack = ^{config_rack, config_q0};
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; FLUSH gives the final write one cycle on the config outputs.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:   if (start) state_next = S_LOAD;
            S_LOAD:   if (last_accept) state_next = S_FLUSH;
`ifdef MEMSTREAM_LOADER_VERIFY_EN
            S_FLUSH:  state_next = S_VERIFY;
            S_VERIFY: if (last_rack) state_next = S_DONE;
`else
            S_FLUSH:  state_next = S_DONE;
            S_VERIFY: state_next = S_IDLE;
`endif
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign busy  = (state_reg != S_IDLE);
    assign done  = (state_reg == S_DONE);
    assign irdy  = (state_reg == S_LOAD);

    // Registered config port: a write the cycle after each accept, reads during VERIFY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_reg <= '0;
            ce_reg     <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            d0_reg     <= '0;
        end else begin
            ce_reg <= 1'b0;
            we_reg <= 1'b0;
            if (start_acc) begin
                wr_cnt_reg <= '0;
            end
            if (accept) begin
                ce_reg     <= 1'b1;
                we_reg     <= 1'b1;
                addr_reg   <= 32'(wr_cnt_reg);
                d0_reg     <= idat;
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
`ifdef MEMSTREAM_LOADER_VERIFY_EN
            if ((state_reg == S_VERIFY) && !rd_all_reg) begin
                ce_reg   <= 1'b1;
                addr_reg <= 32'(rd_cnt_reg);
            end
`endif
        end
    end

`ifdef MEMSTREAM_LOADER_VERIFY_EN
    // Readback bookkeeping: issue DEPTH reads, count DEPTH responses, then compare sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_reg  <= '0;
            rsp_cnt_reg <= '0;
            rd_all_reg  <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            if (start_acc) begin
                rd_cnt_reg  <= '0;
                rsp_cnt_reg <= '0;
                rd_all_reg  <= 1'b0;
                error_reg   <= 1'b0;
            end
            if ((state_reg == S_VERIFY) && !rd_all_reg) begin
                if (rd_cnt_reg == LAST) begin
                    rd_all_reg <= 1'b1;
                end else begin
                    rd_cnt_reg <= rd_cnt_reg + 1'b1;
                end
            end
            if (rack_ok) begin
                rsp_cnt_reg <= rsp_cnt_reg + 1'b1;
                if (last_rack) begin
                    error_reg <= (wsum != (rsum ^ config_q0));
                end
            end
        end
    end

    assign error = error_reg;
`else
    assign error = 1'b0;
`endif

    assign config_ce      = ce_reg;
    assign config_we      = we_reg;
    assign config_address = addr_reg;
    assign config_d0      = d0_reg;

endmodule

// File: tb/tb_memstream_loader.sv
// Bench for memstream_loader: DEPTH=4 and DEPTH=1 instances, a behavioural
// config-memory model per instance, table-driven and randomized loads.
// Readback checks are active when MEMSTREAM_LOADER_VERIFY_EN is defined.
module tb_memstream_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DEPTH=4 instance
    logic        start = 0, ivld = 0;
    logic [31:0] idat = 0;
    logic        busy, done, error, irdy, ce, we;
    logic [31:0] addr, d0;
    logic        rack = 0;
    logic [31:0] q0 = 0;

    // DEPTH=1 instance
    logic        start1 = 0, ivld1 = 0;
    logic [31:0] idat1 = 0;
    logic        busy1, done1, error1, irdy1, ce1, we1;
    logic [31:0] addr1, d01;
    logic        rack1 = 0;
    logic [31:0] q01 = 0;

    memstream_loader #(.DEPTH(4), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .idat(idat), .ivld(ivld), .irdy(irdy),
        .config_ce(ce), .config_we(we), .config_address(addr), .config_d0(d0),
        .config_rack(rack), .config_q0(q0)
    );

    memstream_loader #(.DEPTH(1), .WIDTH(32)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .error(error1),
        .idat(idat1), .ivld(ivld1), .irdy(irdy1),
        .config_ce(ce1), .config_we(we1), .config_address(addr1), .config_d0(d01),
        .config_rack(rack1), .config_q0(q01)
    );

    // Config memory model for the DEPTH=4 instance, two-cycle read response,
    // optional single-bit corruption of word 2 on readback.
    logic [31:0] mem [4];
    logic        rv1 = 0;
    logic [31:0] rq1 = 0;
    logic        corrupt = 0;
    always @(posedge clk) begin
        if (ce && we) mem[addr[1:0]] <= d0;
        rv1  <= ce && !we;
        rq1  <= mem[addr[1:0]] ^ ((corrupt && addr[1:0] == 2'd2) ? 32'd1 : 32'd0);
        rack <= rv1;
        q0   <= rq1;
    end

    // Single-word memory model for the DEPTH=1 instance.
    logic [31:0] mem1 = 0;
    logic        rv11 = 0;
    logic [31:0] rq11 = 0;
    always @(posedge clk) begin
        if (ce1 && we1) mem1 <= d01;
        rv11  <= ce1 && !we1;
        rq11  <= mem1;
        rack1 <= rv11;
        q01   <= rq11;
    end

    // Read addresses seen on the DEPTH=4 port.
    logic [31:0] rd_q[$];
    always @(negedge clk) if (ce && !we) rd_q.push_back(addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    // Wait (bounded) for the done pulse, check it lasts one cycle and busy falls with it.
    task automatic wait_done(input logic exp_err);
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        chk("error_at_done", {31'd0, error}, {31'd0, exp_err});
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    // One DEPTH=4 load. vmode: 0 random ivld, 1 alternating 1010.., 2 always valid.
    // dmode: 0 random data, 1 data = beat index + 1. The model knows LOAD begins the
    // cycle after start and that the k-th valid beat (k<4) lands at address k.
    task automatic run_load(input int vmode, input int dmode, input logic bad);
        int acc, cyc;
        logic v;
        logic [31:0] d;
        corrupt = bad;
        rd_q.delete();
        @(negedge clk);
        start = 1; ivld = 0;
        @(negedge clk);
        start = 0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_irdy", {31'd0, irdy}, 32'd1);
        chk("start_error_clr", {31'd0, error}, 32'd0);
        acc = 0; cyc = 0;
        while (acc < 4 && cyc < 200) begin
            v = (vmode == 0) ? 1'($urandom_range(0, 1)) : (vmode == 1) ? (cyc % 2 == 0) : 1'b1;
            d = (dmode == 1) ? 32'(acc + 1) : $urandom;
            ivld = v; idat = d;
            @(negedge clk);
            chk("ld_ce", {31'd0, ce}, {31'd0, v});
            if (v) begin
                chk("ld_we", {31'd0, we}, 32'd1);
                chk("ld_addr", addr, 32'(acc));
                chk("ld_d0", d0, d);
                acc++;
            end
            chk("ld_irdy", {31'd0, irdy}, (acc < 4) ? 32'd1 : 32'd0);
            cyc++;
        end
        ivld = 1; idat = 32'hdead_beef;   // offered beat must not be taken
        wait_done(bad);
        ivld = 0;
`ifdef MEMSTREAM_LOADER_VERIFY_EN
        chk("rd_count", 32'(rd_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++) chk("rd_addr", rd_q[i], 32'(i));
`endif
    endtask

    typedef struct {
        logic        start;
        logic        ivld;
        logic [31:0] idat;
        logic        e_busy;
        logic        e_irdy;
        logic        e_ce;
        logic [31:0] e_addr;
        logic [31:0] e_d0;
    } vec_t;

    vec_t tbl [5];

    initial begin
        // Back-to-back load of A0..A3: start, then one write per cycle.
        tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'd0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'hA000_0000, 1'b1, 1'b1, 1'b1, 32'd0, 32'hA000_0000};
        tbl[2] = '{1'b0, 1'b1, 32'hA111_1111, 1'b1, 1'b1, 1'b1, 32'd1, 32'hA111_1111};
        tbl[3] = '{1'b0, 1'b1, 32'hA222_2222, 1'b1, 1'b1, 1'b1, 32'd2, 32'hA222_2222};
        tbl[4] = '{1'b0, 1'b1, 32'hA333_3333, 1'b1, 1'b0, 1'b1, 32'd3, 32'hA333_3333};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_irdy", {31'd0, irdy}, 32'd0);
        chk("rst_ce", {31'd0, ce}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        rst = 0;
        @(negedge clk);

        // Test 1: table-driven back-to-back load.
        for (int i = 0; i < 5; i++) begin
            start = tbl[i].start; ivld = tbl[i].ivld; idat = tbl[i].idat;
            @(negedge clk);
            chk("t1_busy", {31'd0, busy}, {31'd0, tbl[i].e_busy});
            chk("t1_irdy", {31'd0, irdy}, {31'd0, tbl[i].e_irdy});
            chk("t1_ce", {31'd0, ce}, {31'd0, tbl[i].e_ce});
            if (tbl[i].e_ce) begin
                chk("t1_we", {31'd0, we}, 32'd1);
                chk("t1_addr", addr, tbl[i].e_addr);
                chk("t1_d0", d0, tbl[i].e_d0);
            end
        end
        start = 0; ivld = 0;
        wait_done(1'b0);

        // Test 2: alternating valid, then randomized stalls and data.
        run_load(1, 0, 1'b0);
        repeat (6) run_load(0, 0, 1'b0);

`ifdef MEMSTREAM_LOADER_VERIFY_EN
        // Test 3: clean readback of 1,2,3,4.
        run_load(2, 1, 1'b0);
        // Test 4: word 2 corrupted on readback; error sticky until next start.
        run_load(2, 1, 1'b1);
        @(negedge clk);
        chk("t4_error_sticky", {31'd0, error}, 32'd1);
        run_load(2, 1, 1'b0);
`endif

        // Test 5: reset after two beats abandons the load.
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0; ivld = 1; idat = 32'h1234_5678;
        @(negedge clk);
        idat = 32'h9abc_def0;
        @(negedge clk);
        ivld = 0;
        #2 rst = 1;
        #1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_irdy", {31'd0, irdy}, 32'd0);
        chk("t5_ce", {31'd0, ce}, 32'd0);
        chk("t5_we", {31'd0, we}, 32'd0);
        chk("t5_addr", addr, 32'd0);
        chk("t5_d0", d0, 32'd0);
        chk("t5_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst = 0;
        run_load(2, 0, 1'b0);

        // Test 6: DEPTH=1, start and valid held high through the whole load.
        begin
            int writes, n;
            @(negedge clk);
            start1 = 1; ivld1 = 1; idat1 = 32'hC0FF_EE01;
            @(negedge clk);
            chk("t6_busy", {31'd0, busy1}, 32'd1);
            chk("t6_ce_idle", {31'd0, ce1}, 32'd0);
            @(negedge clk);
            chk("t6_ce", {31'd0, ce1}, 32'd1);
            chk("t6_we", {31'd0, we1}, 32'd1);
            chk("t6_addr", addr1, 32'd0);
            chk("t6_d0", d01, 32'hC0FF_EE01);
            chk("t6_irdy", {31'd0, irdy1}, 32'd0);
            writes = 1; n = 0;
            while (!done1 && n < 60) begin
                @(negedge clk);
                if (ce1 && we1) writes++;
                n++;
            end
            chk("t6_done", {31'd0, done1}, 32'd1);
            chk("t6_writes", 32'(writes), 32'd1);
            chk("t6_error", {31'd0, error1}, 32'd0);
            start1 = 0; ivld1 = 0;
            @(negedge clk);
            chk("t6_idle", {31'd0, busy1}, 32'd0);
            chk("t6_no_write", {31'd0, ce1}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
